chi_home_completer: RTL

CHI completer (home/slave node) for the single-outstanding requester path. It accepts REQ flits addressed to its node ID and buffers them in a small request FIFO. For each REQ it reads a local word-addressed memory, then returns a FLIT_RSP flit followed by a FLIT_DATA flit carrying the same txn_id, back to the requesting source ID.

---
 rtl/chi_home_completer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/chi_home_completer.sv
// CHI home completer: buffers REQ flits addressed to this node, reads local memory, returns RSP then DATA.
// Optional build macro CHI_COMPLETER_STATS_EN adds saturating req_count/drop_count outputs.
package chi_pkg;
   typedef enum logic [1:0] {
      FLIT_NONE = 2'd0,
      FLIT_REQ  = 2'd1,
      FLIT_RSP  = 2'd2,
      FLIT_DATA = 2'd3
   } flit_type_t;

   typedef struct packed {
      flit_type_t  flit_type;
      logic [7:0]  txn_id;
      logic [3:0]  src_id;
      logic [3:0]  tgt_id;
      logic [31:0] address;
      logic [31:0] data;
   } chi_flit;
endpackage

module chi_home_completer
   import chi_pkg::*;
#(
   parameter logic [3:0]  LOCAL_SRC_ID   = 4'd0,
   parameter int unsigned MEM_DEPTH      = 16,
   parameter int unsigned ADDR_LSB       = 2,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned REQ_FIFO_DEPTH = 4,
   parameter logic [31:0] INIT_PATTERN   = 32'hA5A5_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flit_in_valid,
   input  chi_flit     flit_in,
   output logic        flit_in_ready,
   output logic        flit_valid,
   output chi_flit     flit_out,
   input  logic        flit_ready,
   output logic        busy
`ifdef CHI_COMPLETER_STATS_EN
   ,
   output logic [15:0] req_count,
   output logic [15:0] drop_count
`endif
);

   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
   localparam int unsigned PTR_W = $clog2(REQ_FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, READ, SEND_RSP, SEND_DATA} state_t;

   state_t           state;
   chi_flit          fifo [REQ_FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   chi_flit          cur_req;
   chi_flit          rsp_flit;
   logic [31:0]      rd_data;
   logic [LAT_W-1:0] lat_cnt;
   logic [31:0]      mem [MEM_DEPTH];
   logic [IDX_W-1:0] mem_idx;
   logic             accept;
   logic             is_req;
   logic             push;
   logic             pop;

   assign flit_in_ready = (count != CNT_W'(REQ_FIFO_DEPTH));
   assign accept        = flit_in_valid && flit_in_ready;
   assign is_req        = (flit_in.flit_type == FLIT_REQ) && (flit_in.tgt_id == LOCAL_SRC_ID);
   assign push          = accept && is_req;
   assign pop           = (state == IDLE) && (count != '0);
   assign busy          = (count != '0) || (state != IDLE);
   assign mem_idx       = cur_req.address[ADDR_LSB +: IDX_W];

   // Upper address bits are dropped, so addresses alias modulo MEM_DEPTH words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= INIT_PATTERN ^ 32'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo[wr_ptr] <= flit_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      rsp_flit           = cur_req;
      rsp_flit.flit_type = FLIT_RSP;
      rsp_flit.src_id    = LOCAL_SRC_ID;
      rsp_flit.tgt_id    = cur_req.src_id;
      rsp_flit.data      = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cur_req    <= '0;
         rd_data    <= '0;
         lat_cnt    <= '0;
         flit_valid <= 1'b0;
         flit_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  cur_req <= fifo[rd_ptr];
                  lat_cnt <= LAT_W'(READ_LATENCY - 1);
                  state   <= READ;
               end
            end
            READ: begin
               if (lat_cnt == '0) begin
                  rd_data    <= mem[mem_idx];
                  flit_valid <= 1'b1;
                  flit_out   <= rsp_flit;
                  state      <= SEND_RSP;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            SEND_RSP: begin
               if (flit_ready) begin
                  flit_out.flit_type <= FLIT_DATA;
                  flit_out.data      <= rd_data;
                  state              <= SEND_DATA;
               end
            end
            SEND_DATA: begin
               if (flit_ready) begin
                  flit_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CHI_COMPLETER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_count  <= '0;
         drop_count <= '0;
      end else begin
         if (push && (req_count != '1)) req_count <= req_count + 1'b1;
         if (accept && !is_req && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      end
   end
`endif

endmodule
